opti_sos_feeder: RTL and testbench
==================================

OPTI_SOS_FEEDER -- requirements
Module: opti_sos_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, input sample buffer depth (power of two, 2..64).
REQ-002 SHALL have parameter RESULT_TIMEOUT, default 64, the number of cycles to wait for a section result before abort.
REQ-003 SHALL have port clk input 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port s_valid input 1, upstream sample valid.
REQ-006 SHALL have port s_ready output 1, asserted when the FIFO is not full.
REQ-007 SHALL have port s_data input 24, upstream sample, signed Q2.22.
REQ-008 SHALL have port cfg_we input 1, coefficient shadow write strobe.
REQ-009 SHALL have port cfg_addr input 3, shadow select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored.
REQ-010 SHALL have port cfg_wdata input 24, coefficient value, signed Q2.22.
REQ-011 SHALL have port cfg_commit input 1, requests copying shadow to active at the next sample boundary.
REQ-012 SHALL have port sos_valid output 1, one-cycle issue strobe to the section's data_valid_in.
REQ-013 SHALL have port sos_data output 24, sample to the section's data_in.
REQ-014 SHALL have ports b0, b1, b2, a1, a2 output 24 each, the active coefficient set.
REQ-015 SHALL have port sos_done input 1, the section's data_valid_out returned.
REQ-016 SHALL have ports busy output 1 and timeout_err output 1 (sticky).

Function
REQ-017 SHALL buffer accepted samples (s_valid and s_ready) in a FIFO with no loss and in-order delivery.
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, COMMIT.
REQ-019 IDLE: SHALL go to COMMIT if a commit is pending, else to ISSUE if the FIFO is non-empty, else hold.
REQ-020 ISSUE: SHALL pop one sample, drive sos_valid=1 for exactly one cycle with sos_data equal to the popped sample, then go to WAIT.
REQ-021 WAIT: SHALL hold sos_valid=0; on sos_done, go to IDLE; if the wait counter reaches RESULT_TIMEOUT, set timeout_err, go to IDLE, and do not reissue the sample.
REQ-022 SHALL allow at most one sample in flight, so section feedback y1/y2 is always settled before the next issue.
REQ-023 COMMIT: SHALL copy all five shadow coefficients to the active outputs atomically in one cycle, clear the pending flag, and return to IDLE.
REQ-024 Active coefficients SHALL never change while in ISSUE or WAIT.
REQ-025 A cfg_commit in any state SHALL set the pending flag; repeated commits before service SHALL merge into one.
REQ-026 A cfg_we coinciding with the COMMIT copy cycle SHALL update the shadow only; the active set takes the pre-write value.
REQ-027 When the FIFO is full, s_ready SHALL be 0; a simultaneous push and pop on a full FIFO SHALL be blocked on the push side.
REQ-028 An sos_done outside WAIT SHALL be ignored.
REQ-029 busy SHALL be 1 in ISSUE, WAIT, and COMMIT, or when the FIFO is non-empty.

Reset
REQ-030 Reset SHALL give: state IDLE, FIFO empty, s_ready=1 after reset, sos_valid=0, sos_data=0, all shadow and active coefficients 0, pending=0, timeout_err=0, busy=0.
REQ-031 Reset mid-WAIT SHALL abandon the in-flight sample without a further issue.

Configuration
REQ-032 SHALL have macro OPTI_FEEDER_STATS_EN. When defined, it adds outputs issued_cnt (32-bit, incremented per ISSUE) and timeout_cnt (16-bit, saturating), both reset to 0. When undefined, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-033 Package opti_pkg SHALL hold the Q2.22 sample typedef (signed 24-bit), the coefficient-index constants 0..4, and the feeder state enum.
REQ-034 The FIFO SHALL be a sub-module opti_sync_fifo, parameterised by width and depth.

Verification
REQ-035 Reset, then push 3 samples (0x100000, 0x200000, 0x300000) with sos_done returned 16 cycles after each issue: 3 single-cycle issues in order, spaced at least 17 cycles apart.
REQ-036 Push 9 samples back-to-back with FIFO_DEPTH=8 while the first is in WAIT: s_ready drops to 0 after 8 accepted, no sample is lost, and output order matches input order.
REQ-037 Write b0=0x400000 and assert cfg_commit during WAIT: b0 output stays old until sos_done, then changes in the COMMIT cycle before the next issue.
REQ-038 Issue a sample and never return sos_done: timeout_err=1 exactly RESULT_TIMEOUT cycles after entering WAIT, then the next FIFO sample issues.
REQ-039 Assert rst_n=0 for 1 cycle in WAIT with 2 samples queued: all outputs return to reset values, the FIFO is empty, and no sos_valid occurs afterwards.
REQ-040 With OPTI_FEEDER_STATS_EN defined, 5 issues and 1 timeout give issued_cnt=5 and timeout_cnt=1.

Source files
------------

// File: rtl/opti_pkg.sv
// Shared types and constants for the SOS feeder: Q2.22 sample type,
// coefficient-bank layout and the feeder state encoding.
package opti_pkg;

  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned CFG_ADDR_W = 3;

  // Signed Q2.22 sample / coefficient word
  typedef logic signed [SAMPLE_W-1:0] q2_22_t;

  // Coefficient select codes on cfg_addr; codes 5..7 are ignored
  localparam logic [CFG_ADDR_W-1:0] COEF_B0 = 3'd0;
  localparam logic [CFG_ADDR_W-1:0] COEF_B1 = 3'd1;
  localparam logic [CFG_ADDR_W-1:0] COEF_B2 = 3'd2;
  localparam logic [CFG_ADDR_W-1:0] COEF_A1 = 3'd3;
  localparam logic [CFG_ADDR_W-1:0] COEF_A2 = 3'd4;

  // One full biquad coefficient set
  typedef struct packed {
    q2_22_t b0;
    q2_22_t b1;
    q2_22_t b2;
    q2_22_t a1;
    q2_22_t a2;
  } coef_set_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } feeder_state_t;

  // Return cur with the addressed coefficient replaced; unknown codes leave it intact
  function automatic coef_set_t coef_write(input coef_set_t cur,
                                           input logic [CFG_ADDR_W-1:0] addr,
                                           input q2_22_t val);
    coef_set_t nxt;
    nxt = cur;
    case (addr)
      COEF_B0: nxt.b0 = val;
      COEF_B1: nxt.b1 = val;
      COEF_B2: nxt.b2 = val;
      COEF_A1: nxt.a1 = val;
      COEF_A2: nxt.a2 = val;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/opti_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of two.
// Pushes into a full FIFO are dropped, even when a pop happens the same cycle.
module opti_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/opti_sos_feeder.sv
// Feeds buffered samples one at a time into a biquad (SOS) section and owns
// its coefficient bank. Only one sample is in flight, so the section's
// feedback state is settled before the next issue. Coefficient commits are
// deferred to a sample boundary and copied atomically.
// Optional build macro OPTI_FEEDER_STATS_EN adds issued_cnt / timeout_cnt.
module opti_sos_feeder
  import opti_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned RESULT_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  cfg_we,
  input  logic [CFG_ADDR_W-1:0] cfg_addr,
  input  logic [SAMPLE_W-1:0]   cfg_wdata,
  input  logic                  cfg_commit,
  output logic                  sos_valid,
  output logic [SAMPLE_W-1:0]   sos_data,
  output logic [SAMPLE_W-1:0]   b0,
  output logic [SAMPLE_W-1:0]   b1,
  output logic [SAMPLE_W-1:0]   b2,
  output logic [SAMPLE_W-1:0]   a1,
  output logic [SAMPLE_W-1:0]   a2,
  input  logic                  sos_done,
  output logic                  busy,
  output logic                  timeout_err
`ifdef OPTI_FEEDER_STATS_EN
  ,
  output logic [31:0]           issued_cnt,
  output logic [15:0]           timeout_cnt
`endif
);

  localparam int unsigned TMO_W = $clog2(RESULT_TIMEOUT + 1);

  feeder_state_t       state;
  feeder_state_t       state_d;
  logic                issue_start_c;
  logic                commit_c;
  logic                tmo_hit_c;
  logic                pending;
  logic [TMO_W-1:0]    wait_cnt;
  coef_set_t           shadow;
  coef_set_t           active;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_rd_data;

  opti_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (s_valid && !fifo_full),
    .wr_data (s_data),
    .pop     (issue_start_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign s_ready = !fifo_full;
  assign busy    = (state != ST_IDLE) || !fifo_empty;
  assign b0      = active.b0;
  assign b1      = active.b1;
  assign b2      = active.b2;
  assign a1      = active.a1;
  assign a2      = active.a2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state and control strobes; commits win over issues at a boundary
  always_comb begin
    state_d       = state;
    issue_start_c = 1'b0;
    commit_c      = 1'b0;
    tmo_hit_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_d = ST_COMMIT;
        end else if (!fifo_empty) begin
          state_d       = ST_ISSUE;
          issue_start_c = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sos_done) begin
          state_d = ST_IDLE;
        end else if (wait_cnt == TMO_W'(RESULT_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          tmo_hit_c = 1'b1;
        end
      end
      ST_COMMIT: begin
        commit_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Cycles spent in WAIT for the current sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wait_cnt <= '0;
    else if (state == ST_WAIT) wait_cnt <= wait_cnt + TMO_W'(1);
    else                       wait_cnt <= '0;
  end

  // Issue strobe and sample, popped on entry to ISSUE so they are visible during it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sos_valid <= 1'b0;
      sos_data  <= '0;
    end else begin
      sos_valid <= issue_start_c;
      if (issue_start_c) sos_data <= fifo_rd_data;
    end
  end

  // Commit request; a new request in the copy cycle stays pending for another copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pending <= 1'b0;
    else if (cfg_commit) pending <= 1'b1;
    else if (commit_c)   pending <= 1'b0;
  end

  // Shadow and active banks; the copy reads the shadow before any same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (cfg_we)   shadow <= coef_write(shadow, cfg_addr, cfg_wdata);
      if (commit_c) active <= shadow;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         timeout_err <= 1'b0;
    else if (tmo_hit_c) timeout_err <= 1'b1;
  end

`ifdef OPTI_FEEDER_STATS_EN
  // Issue counter (wraps) and saturating timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (issue_start_c) issued_cnt <= issued_cnt + 32'd1;
      if (tmo_hit_c && (timeout_cnt != 16'hFFFF)) timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_opti_sos_feeder.sv
// Directed bench for opti_sos_feeder with a simple section model returning
// sos_done a fixed number of cycles after each issue (0 = never).
module tb_opti_sos_feeder;

  localparam int unsigned FIFO_DEPTH     = 8;
  localparam int unsigned RESULT_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [23:0] cfg_wdata = '0;
  logic        cfg_commit = 1'b0;
  logic        sos_valid;
  logic [23:0] sos_data;
  logic [23:0] b0, b1, b2, a1, a2;
  logic        sos_done = 1'b0;
  logic        busy;
  logic        timeout_err;
`ifdef OPTI_FEEDER_STATS_EN
  logic [31:0] issued_cnt;
  logic [15:0] timeout_cnt;
`endif

  wire [119:0] coefs = {b0, b1, b2, a1, a2};

  int errors = 0;
  int checks = 0;

  // Section model / issue log state
  logic [23:0] issued_q[$];
  int          issue_cyc[$];
  int          cyc = 0;
  int          done_delay = 16;
  int          done_cnt = 0;
  int          dbl_valid = 0;
  int          tmo_cyc = -1;
  logic        vprev = 1'b0;
  logic        tmo_prev = 1'b0;

  opti_sos_feeder #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .RESULT_TIMEOUT (RESULT_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_commit  (cfg_commit),
    .sos_valid   (sos_valid),
    .sos_data    (sos_data),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2),
    .sos_done    (sos_done),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef OPTI_FEEDER_STATS_EN
    ,
    .issued_cnt  (issued_cnt),
    .timeout_cnt (timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Section model: logs issues, returns sos_done done_delay cycles after each
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      sos_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) sos_done = 1'b1;
      end
      if (sos_valid) begin
        if (vprev) dbl_valid++;
        issued_q.push_back(sos_data);
        issue_cyc.push_back(cyc);
        if (done_delay > 0) done_cnt = done_delay;
      end
      vprev = sos_valid;
      if (timeout_err && !tmo_prev) tmo_cyc = cyc;
      tmo_prev = timeout_err;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    issued_q.delete();
    issue_cyc.delete();
    dbl_valid = 0;
  endtask

  // Present one sample until accepted; an expired bound counts as a failure
  task automatic push(input logic [23:0] d);
    int   n;
    logic acc;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    forever begin
      acc = s_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL push_bound: sample %h not accepted, required acceptance", d);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget, output int got);
    int k;
    k = 0;
    while (issued_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    got = issued_q.size();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (sos_valid !== 1'b0) begin errors++; $display("FAIL reset_sos_valid: got %b want 0", sos_valid); end
    checks++; if (sos_data !== 24'h0) begin errors++; $display("FAIL reset_sos_data: got %h want 0", sos_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (coefs !== 120'h0) begin errors++; $display("FAIL reset_coefs: got %h want 0", coefs); end
  endtask

  // Three samples, section answers 16 cycles after each issue
  task automatic test_basic();
    int got;
    clear_log();
    done_delay = 16;
    push(24'h100000);
    push(24'h200000);
    push(24'h300000);
    wait_issues(3, 200, got);
    wait_idle(100);
    checks++; if (got !== 3) begin errors++; $display("FAIL basic_count: got %0d issues want 3", got); end
    if (got >= 3) begin
      checks++; if (issued_q[0] !== 24'h100000) begin errors++; $display("FAIL basic_data0: got %h want 100000", issued_q[0]); end
      checks++; if (issued_q[1] !== 24'h200000) begin errors++; $display("FAIL basic_data1: got %h want 200000", issued_q[1]); end
      checks++; if (issued_q[2] !== 24'h300000) begin errors++; $display("FAIL basic_data2: got %h want 300000", issued_q[2]); end
      checks++; if (issue_cyc[1] - issue_cyc[0] < 17) begin errors++; $display("FAIL basic_gap01: got %0d cycles want >=17", issue_cyc[1] - issue_cyc[0]); end
      checks++; if (issue_cyc[2] - issue_cyc[1] < 17) begin errors++; $display("FAIL basic_gap12: got %0d cycles want >=17", issue_cyc[2] - issue_cyc[1]); end
    end
    checks++; if (dbl_valid !== 0) begin errors++; $display("FAIL basic_single_strobe: got %0d multi-cycle strobes want 0", dbl_valid); end
    checks++; if (issued_q.size() !== 3) begin errors++; $display("FAIL basic_no_extra: got %0d issues want 3", issued_q.size()); end
  endtask

  // Fill the FIFO while the first sample is in flight
  task automatic test_back_to_back();
    int          got;
    int          idx;
    int          guard;
    int          acc_before_full;
    logic        acc;
    logic [23:0] exp_q[$];
    clear_log();
    done_delay = 16;
    push(24'h0A0001);
    exp_q.push_back(24'h0A0001);
    wait_issues(1, 50, got);
    idx = 0;
    guard = 0;
    acc_before_full = -1;
    s_valid = 1'b1;
    s_data  = 24'h0B0000;
    while (idx < 9 && guard < 300) begin
      acc = s_ready;
      tick();
      guard++;
      if (acc) begin
        exp_q.push_back(s_data);
        idx++;
        s_data = 24'h0B0000 + 24'(idx);
      end
      if (!s_ready && acc_before_full < 0) acc_before_full = idx;
    end
    s_valid = 1'b0;
    checks++; if (acc_before_full !== 8) begin errors++; $display("FAIL b2b_full_point: got s_ready drop after %0d want 8", acc_before_full); end
    checks++; if (idx !== 9) begin errors++; $display("FAIL b2b_accepted: got %0d want 9", idx); end
    wait_issues(10, 400, got);
    wait_idle(100);
    checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count: got %0d issues want 10", got); end
    for (int i = 0; i < 10; i++) begin
      if (i < issued_q.size() && i < exp_q.size()) begin
        checks++;
        if (issued_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, issued_q[i], exp_q[i]); end
      end
    end
  endtask

  // Commit requested during WAIT takes effect only after the result returns
  task automatic test_commit_in_wait();
    int   got;
    int   k;
    logic done_seen;
    logic b0_changed;
    logic chg_before_done;
    int   n_at_chg;
    clear_log();
    done_delay = 16;
    push(24'h111111);
    wait_issues(1, 50, got);
    tick();
    tick();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 24'h400000; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    push(24'h222222);
    checks++; if (b0 !== 24'h0) begin errors++; $display("FAIL commit_hold_b0: got %h want 0", b0); end
    done_seen = 1'b0; b0_changed = 1'b0; chg_before_done = 1'b0; n_at_chg = -1; k = 0;
    while (issued_q.size() < 2 && k < 100) begin
      if (!b0_changed && b0 === 24'h400000) begin
        b0_changed = 1'b1;
        chg_before_done = !done_seen;
        n_at_chg = issued_q.size();
      end
      if (sos_done) done_seen = 1'b1;
      tick();
      k++;
    end
    wait_idle(100);
    checks++; if (b0_changed !== 1'b1) begin errors++; $display("FAIL commit_b0_applied: got %b want 1", b0_changed); end
    checks++; if (chg_before_done !== 1'b0) begin errors++; $display("FAIL commit_early: got change before done=%b want 0", chg_before_done); end
    checks++; if (n_at_chg !== 1) begin errors++; $display("FAIL commit_before_issue: got %0d issues at change want 1", n_at_chg); end
    checks++; if (b0 !== 24'h400000) begin errors++; $display("FAIL commit_b0_value: got %h want 400000", b0); end
    checks++; if (b1 !== 24'h0) begin errors++; $display("FAIL commit_b1_untouched: got %h want 0", b1); end
    if (issued_q.size() >= 2) begin
      checks++; if (issued_q[1] !== 24'h222222) begin errors++; $display("FAIL commit_next_data: got %h want 222222", issued_q[1]); end
    end
  endtask

  // Shadow write during the copy cycle does not reach the active bank
  task automatic test_commit_collision();
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 24'h0AAAAA; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL collide_in_commit: got busy %b want 1", busy); end
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 24'h055555;
    tick();
    cfg_we = 1'b0;
    checks++; if (b1 !== 24'h0AAAAA) begin errors++; $display("FAIL collide_b1_pre: got %h want 0aaaaa", b1); end
    checks++; if (b0 !== 24'h400000) begin errors++; $display("FAIL collide_b0_kept: got %h want 400000", b0); end
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_wdata = 24'hFFFFFF; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    repeat (4) tick();
    checks++; if (b1 !== 24'h055555) begin errors++; $display("FAIL collide_b1_post: got %h want 055555", b1); end
    checks++; if ({b2, a1, a2} !== 72'h0) begin errors++; $display("FAIL collide_ignored_addr: got %h want 0", {b2, a1, a2}); end
  endtask

  // Section never answers: abort after RESULT_TIMEOUT WAIT cycles, move on
  task automatic test_timeout();
    int got;
    clear_log();
    done_delay = 0;
    tmo_cyc = -1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pre: got %b want 0", timeout_err); end
    push(24'h333333);
    push(24'h444444);
    wait_issues(2, 200, got);
    checks++; if (got !== 2) begin errors++; $display("FAIL tmo_count: got %0d issues want 2", got); end
    if (got >= 2) begin
      // WAIT is entered the cycle after the issue strobe
      checks++; if (tmo_cyc - issue_cyc[0] !== RESULT_TIMEOUT + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", tmo_cyc - issue_cyc[0], RESULT_TIMEOUT + 1); end
      checks++; if (issued_q[1] !== 24'h444444) begin errors++; $display("FAIL tmo_no_reissue: got %h want 444444", issued_q[1]); end
      checks++; if (issue_cyc[1] <= tmo_cyc) begin errors++; $display("FAIL tmo_next_after: got issue %0d vs timeout %0d want later", issue_cyc[1], tmo_cyc); end
    end
    wait_idle(200);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
  endtask

  // Reset pulse while a sample is in flight and two are queued
  task automatic test_reset_in_wait();
    int got;
    clear_log();
    done_delay = 16;
    push(24'h555555);
    wait_issues(1, 50, got);
    push(24'h666666);
    push(24'h777777);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_pre_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    done_cnt = 0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstw_s_ready: got %b want 1", s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b want 0", busy); end
    checks++; if (sos_valid !== 1'b0) begin errors++; $display("FAIL rstw_sos_valid: got %b want 0", sos_valid); end
    checks++; if (sos_data !== 24'h0) begin errors++; $display("FAIL rstw_sos_data: got %h want 0", sos_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstw_timeout_err: got %b want 0", timeout_err); end
    checks++; if (coefs !== 120'h0) begin errors++; $display("FAIL rstw_coefs: got %h want 0", coefs); end
    repeat (100) tick();
    checks++; if (issued_q.size() !== 1) begin errors++; $display("FAIL rstw_no_issue: got %0d issues want 1", issued_q.size()); end
  endtask

`ifdef OPTI_FEEDER_STATS_EN
  // Five issues, the last one timing out
  task automatic test_stats();
    int got;
    clear_log();
    done_delay = 16;
    checks++; if (issued_cnt !== 32'd0) begin errors++; $display("FAIL stats_reset_issued: got %0d want 0", issued_cnt); end
    checks++; if (timeout_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset_tmo: got %0d want 0", timeout_cnt); end
    for (int i = 0; i < 4; i++) push(24'h010000 + 24'(i));
    wait_issues(4, 200, got);
    wait_idle(100);
    done_delay = 0;
    push(24'h020000);
    wait_issues(5, 50, got);
    wait_idle(200);
    checks++; if (issued_cnt !== 32'd5) begin errors++; $display("FAIL stats_issued: got %0d want 5", issued_cnt); end
    checks++; if (timeout_cnt !== 16'd1) begin errors++; $display("FAIL stats_tmo: got %0d want 1", timeout_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_commit_in_wait();
    test_commit_collision();
    test_timeout();
    test_reset_in_wait();
`ifdef OPTI_FEEDER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
